seg7_display_capture: RTL and testbench
=======================================

# seg7_display_capture

Receive-side counterpart of the multiplexed 7-segment display driver. It watches a driver's scanned `display_led_segments` and `display_segment_enable` lines, de-glitches each scan slot, and decodes the segment pattern back to a hex nibble. It reassembles the 6-digit frame (`data`, `digit_enable`, `decimal_point_enable`) and publishes it once per complete scan. Used for driver loopback self-check and for reading an external board's display.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required to accept a slot; range 1..255.
- `TIMEOUT_CYCLES`, default 100000: cycles without an accepted slot before `display_lost` asserts; must be > 0.
- `SEG_ACTIVE_LOW`, default 0: 1 means a lit segment is driven 0.
- `EN_ACTIVE_LOW`, default 0: 1 means the enabled digit is driven 0.
- `clk` input, 1 bit: single clock; all logic rises on this edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `display_led_segments` input, 8 bits: bit0..6 = segments a..g, bit7 = dp. Asynchronous to `clk`.
- `display_segment_enable` input, 6 bits: bit k selects digit k. Asynchronous to `clk`.
- `data` output, 24 bits: digit k is at `data[4k+3:4k]`.
- `digit_enable` output, 6 bits: 1 means digit k was lit (not blank) in the last frame.
- `decimal_point_enable` output, 6 bits: dp state per digit.
- `frame_valid` output, 1 bit: one-cycle pulse when the outputs above update.
- `decode_error` output, 1 bit: sticky until the next publish. Set by an undecodable pattern or a multi-hot enable.
- `display_lost` output, 1 bit: level; high while the timeout counter is expired.

## Operation
- Inputs pass through a 2-FF synchronizer. Polarity is normalized after the synchronizer, so internally 1 always means lit or enabled.
- Slot FSM states:
  - IDLE: enable == 0.
  - FILTER: counting stability.
  - HOLD: slot accepted, waiting for a change.
- Any change of the normalized {enable, segments} versus the previous sample sends the FSM to FILTER with count = 1, or to IDLE if the new enable == 0.
- In FILTER, the count increments on each identical sample. Reaching `STABLE_CYCLES` accepts the slot and moves to HOLD.
- HOLD ignores further identical samples, so each enable pulse is accepted exactly once.
- On accept with a one-hot enable at digit k:
  - Segments a..g are decoded via the hex table (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Match: shadow nibble[k] = value, shadow en[k] = 1.
  - a..g all off: nibble[k] = 0, en[k] = 0.
  - Any other pattern: nibble[k] = 0, en[k] = 0, and the error flag is set.
  - In every case dp[k] = bit7, and seen[k] is set.
- On accept with a multi-hot enable: the error flag is set and the shadow registers and `seen` are untouched.
- A repeat of digit k before the frame completes overwrites the shadow value with no error.
- Publish: when `seen` == 6'b111111, in the cycle following the accept:
  - shadow values are copied to the outputs;
  - `decode_error` = the accumulated error flag;
  - `frame_valid` pulses;
  - `seen` and the error flag clear.
- Timeout counter: reset on every accept. On reaching `TIMEOUT_CYCLES` it saturates, `display_lost` asserts, and `seen` clears. `display_lost` deasserts on the next accept.

## Timing
- Reset values:
  - `data` = 0, `digit_enable` = 0, `decimal_point_enable` = 0.
  - `frame_valid` = 0, `decode_error` = 0, `display_lost` = 0.
  - FSM = IDLE, `seen` = 0, timeout counter = 0.
- Latency from a pin change to accept: 2 sync cycles + `STABLE_CYCLES` cycles. Publish follows 1 cycle after the completing accept.
- A slot shorter than `STABLE_CYCLES` + 1 stable cycles at the sync output is never accepted.
- Accept and timeout expiry in the same cycle: accept wins, the counter resets, and `display_lost` stays low.
- Reset asserted mid-frame discards all shadow state immediately. The first publish after release needs a full fresh scan.

## Structure
- Package `seg7_pkg` holds:
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP);
  - the 16-entry hex-to-segment table, shared with the driver;
  - the FSM state enum.
- Sub-module `seg7_pattern_decoder`: combinational, 7-bit pattern to {valid, blank, nibble}.

## Test plan
- Drive the real driver with `data` = 24'h123456, `digit_enable` = 6'b111111, `decimal_point_enable` = 6'b010101, `CLK_DIVIDE` = 0, in loopback. Required: `frame_valid` pulses and the outputs equal exactly those values with `decode_error` = 0.
- Model-driven scan with digit 3 segments = 7'h00. Required: `digit_enable` = 6'b110111, `data[15:12]` = 0, no error.
- Digit 2 pattern = 7'h49 (invalid). Required: the next publish has `decode_error` = 1; the following clean frame clears it.
- Glitch `display_led_segments` for `STABLE_CYCLES` − 1 cycles within a slot. Required: the value accepted is the settled one and is accepted once only; sweep glitch widths 1..3 with `STABLE_CYCLES` = 4.
- Enable = 6'b000011 held stable. Required: error set, `seen` unchanged, no publish.
- Stop scanning for `TIMEOUT_CYCLES` cycles. Required: `display_lost` = 1 from cycle `TIMEOUT_CYCLES`; it drops on the first accept. Also assert `reset_n` after 3 of 6 slots: no publish until a full new scan.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment encoding, hex table and capture FSM states
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam int DIGITS = 6;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic [1:0] {IDLE, FILTER, HOLD} slot_state_t;
endpackage

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: maps a gfedcba pattern back to its hex nibble
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic       blank,
  output logic [3:0] nibble
);
  assign blank = pattern == 7'h00;
  // search the shared table; entries are unique so at most one hit
  always_comb begin
    valid = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++)
      if (pattern == HEX_SEG[i]) begin
        valid = 1'b1;
        nibble = 4'(i);
      end
  end
endmodule

// File: rtl/seg7_display_capture.sv
// seg7_display_capture: recovers a 6-digit hex frame from a scanned 7-segment display bus
module seg7_display_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit EN_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  display_led_segments,
  input  logic [5:0]  display_segment_enable,
  output logic [23:0] data,
  output logic [5:0]  digit_enable,
  output logic [5:0]  decimal_point_enable,
  output logic        frame_valid,
  output logic        decode_error,
  output logic        display_lost
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0] SMAX = 8'(STABLE_CYCLES);
  localparam logic [13:0] RAW_IDLE = {{DIGITS{EN_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};
  logic [13:0] sync1, sync2, prev, cur;
  slot_state_t state, state_next;
  logic [7:0] cnt, cnt_next;
  logic accept, one_hot, pat_valid, pat_blank, acc_err, publish, lost_next, err;
  logic [3:0] pat_nibble;
  logic [5:0] slot_en, seen, shadow_en, shadow_dp;
  logic [23:0] shadow_nib;
  logic [TW-1:0] tcnt;
  // xor with the idle level normalizes polarity: 1 = lit / enabled
  assign cur = sync2 ^ RAW_IDLE;
  assign slot_en = cur[13:8];
  assign one_hot = (slot_en != 6'd0) && ((slot_en & (slot_en - 6'd1)) == 6'd0);
  assign acc_err = accept && (!one_hot || (!pat_valid && !pat_blank));
  assign publish = seen == 6'h3F;
  assign lost_next = !accept && (tcnt >= TMAX - 1'b1);
  assign display_lost = tcnt == TMAX;
  seg7_pattern_decoder u_dec (
    .pattern(cur[SEG_G:SEG_A]),
    .valid  (pat_valid),
    .blank  (pat_blank),
    .nibble (pat_nibble)
  );
  // two-flop synchronizer, reset to the undriven (idle) pin level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {sync2, sync1} <= {RAW_IDLE, RAW_IDLE};
    else {sync2, sync1} <= {sync1, {display_segment_enable, display_led_segments}};
  // slot state, stability count and previous sample
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 8'd0;
      prev <= 14'd0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      prev <= cur;
    end
  // any change restarts filtering; one more identical sample past the count accepts once
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    accept = 1'b0;
    if (cur != prev) begin
      state_next = (slot_en == 6'd0) ? IDLE : FILTER;
      cnt_next = 8'd1;
    end else if (state == FILTER) begin
      if (cnt >= SMAX) begin
        state_next = HOLD;
        accept = 1'b1;
      end else cnt_next = cnt + 8'd1;
    end
  end
  // shadow frame assembly, publish, error accumulation and loss timeout
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data <= 24'd0;
      digit_enable <= 6'd0;
      decimal_point_enable <= 6'd0;
      frame_valid <= 1'b0;
      decode_error <= 1'b0;
      err <= 1'b0;
      seen <= 6'd0;
      tcnt <= '0;
      shadow_nib <= 24'd0;
      shadow_en <= 6'd0;
      shadow_dp <= 6'd0;
    end else begin
      frame_valid <= publish;
      decode_error <= (publish ? err : decode_error) | acc_err;
      err <= (publish ? 1'b0 : err) | acc_err;
      seen <= ((publish || lost_next) ? 6'd0 : seen) | ((accept && one_hot) ? slot_en : 6'd0);
      tcnt <= accept ? '0 : lost_next ? TMAX : tcnt + 1'b1;
      if (publish) begin
        data <= shadow_nib;
        digit_enable <= shadow_en;
        decimal_point_enable <= shadow_dp;
      end
      for (int k = 0; k < DIGITS; k++)
        if (accept && one_hot && slot_en[k]) begin
          shadow_nib[4*k +: 4] <= pat_valid ? pat_nibble : 4'd0;
          shadow_en[k] <= pat_valid;
          shadow_dp[k] <= cur[SEG_DP];
        end
    end
endmodule

// File: tb/tb_seg7_display_capture.sv
// tb_seg7_display_capture: table, corner-case and random checks against a frame-level model
module tb_seg7_display_capture;
  localparam int STABLE = 4;
  localparam int TMO = 200;
  typedef struct {
    logic [23:0] d;
    logic [5:0] en;
    logic [5:0] dp;
    logic err;
  } frame_t;
  typedef struct {
    logic [41:0] segs;
    logic [5:0] dp;
    logic [23:0] xd;
    logic [5:0] xen;
    logic xerr;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] seg_in = 8'd0;
  logic [5:0] en_in = 6'd0;
  logic [23:0] data;
  logic [5:0] digit_enable, decimal_point_enable;
  logic frame_valid, decode_error, display_lost;
  int checks = 0, failures = 0, frames = 0, cyc = 0, fv_cyc = 0;
  logic [23:0] last_d = 24'd0;
  logic [5:0] last_en = 6'd0, last_dp = 6'd0;
  logic last_err = 1'b0;
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_nib [6];
  logic [5:0] m_en = 6'd0, m_dp = 6'd0, m_seen = 6'd0;
  logic m_err = 1'b0;
  frame_t exp_q[$];
  vec_t tbl [5];

  seg7_display_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO),
                         .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .display_led_segments(seg_in),
    .display_segment_enable(en_in), .data(data), .digit_enable(digit_enable),
    .decimal_point_enable(decimal_point_enable), .frame_valid(frame_valid),
    .decode_error(decode_error), .display_lost(display_lost));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 6'd0; m_dp = 6'd0; m_seen = 6'd0; m_err = 1'b0;
    for (int k = 0; k < 6; k++) m_nib[k] = 4'd0;
    exp_q.delete();
  endtask

  task automatic model_slot(input logic [5:0] en, input logic [7:0] s);
    int k, hits;
    logic ok;
    logic [3:0] n;
    logic [23:0] d;
    if (en == 6'd0) return;
    hits = 0; k = 0;
    for (int i = 0; i < 6; i++) if (en[i]) begin hits++; k = i; end
    if (hits != 1) begin m_err = 1'b1; return; end
    ok = 1'b0; n = 4'd0;
    for (int v = 0; v < 16; v++) if (hex_tab[v] == s[6:0]) begin ok = 1'b1; n = 4'(v); end
    if (!ok && s[6:0] != 7'd0) m_err = 1'b1;
    m_nib[k] = n; m_en[k] = ok; m_dp[k] = s[7]; m_seen[k] = 1'b1;
    if (m_seen == 6'h3F) begin
      for (int i = 0; i < 6; i++) d[4*i +: 4] = m_nib[i];
      exp_q.push_back('{d, m_en, m_dp, m_err});
      m_seen = 6'd0; m_err = 1'b0;
    end
  endtask

  task automatic put(input logic [5:0] e, input logic [7:0] s, input int n);
    en_in = e; seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [5:0] e, input logic [7:0] s);
    model_slot(e, s);
    put(e, s, 10);
    put(6'd0, 8'd0, 4);
  endtask

  task automatic scan(input logic [41:0] s, input logic [5:0] dp, input int from, input int to);
    for (int k = from; k <= to; k++) slot(6'(1 << k), {dp[k], s[7*k +: 7]});
  endtask

  task automatic wait_frame(input int f0);
    for (int i = 0; i < 50 && frames == f0; i++) @(negedge clk);
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (reset_n && frame_valid) begin
      frames++; fv_cyc = cyc;
      last_d = data; last_en = digit_enable; last_dp = decimal_point_enable; last_err = decode_error;
      chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        chk("frame_data", data, f.d);
        chk("frame_digit_en", digit_enable, f.en);
        chk("frame_dp", decimal_point_enable, f.dp);
        chk("frame_err", decode_error, f.err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, target;
    logic [5:0] e;
    logic [7:0] s;
    tbl[0] = '{{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b010101, 24'h123456, 6'h3F, 1'b0};
    tbl[1] = '{{7'h39, 7'h7C, 7'h00, 7'h77, 7'h6F, 7'h7F}, 6'b000000, 24'hCB0A98, 6'b110111, 1'b0};
    tbl[2] = '{{7'h06, 7'h3F, 7'h71, 7'h49, 7'h79, 7'h5E}, 6'b100000, 24'h10F0ED, 6'b111011, 1'b1};
    tbl[3] = '{{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 6'b111111, 24'h000000, 6'h3F, 1'b0};
    tbl[4] = '{{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7F, 7'h07}, 6'b101010, 24'hFEDC87, 6'h3F, 1'b0};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 0);
    chk("rst_digit_en", digit_enable, 0);
    chk("rst_dp", decimal_point_enable, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_decode_error", decode_error, 0);
    chk("rst_lost", display_lost, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    // table-driven full scans
    for (int t = 0; t < 5; t++) begin
      f0 = frames;
      scan(tbl[t].segs, tbl[t].dp, 0, 5);
      wait_frame(f0);
      chk("tbl_frame_count", frames, f0 + 1);
      chk("tbl_data", last_d, tbl[t].xd);
      chk("tbl_digit_en", last_en, tbl[t].xen);
      chk("tbl_dp", last_dp, tbl[t].dp);
      chk("tbl_err", last_err, tbl[t].xerr);
    end
    // multi-hot enable: error immediately, no publish, seen untouched
    chk("pre_multihot_err", decode_error, 0);
    f0 = frames;
    scan(tbl[3].segs, 6'd0, 0, 4);
    model_slot(6'b000011, 8'h06);
    put(6'b000011, 8'h06, 10);
    put(6'd0, 8'd0, 4);
    chk("multihot_err", decode_error, 1);
    chk("multihot_no_publish", frames, f0);
    scan(tbl[3].segs, 6'd0, 5, 5);
    wait_frame(f0);
    chk("multihot_then_publish", frames, f0 + 1);
    chk("multihot_frame_err", last_err, 1);
    // glitches shorter than the filter window on digit 0
    for (int w = 1; w <= 3; w++) begin
      f0 = frames;
      model_slot(6'd1, 8'h6D);
      put(6'd1, 8'h6D, 1);
      put(6'd1, 8'h49, w);
      put(6'd1, 8'h6D, 10);
      put(6'd0, 8'd0, 4);
      scan(tbl[3].segs, 6'd0, 1, 5);
      wait_frame(f0);
      chk("glitch_frame_count", frames, f0 + 1);
      chk("glitch_digit0", last_d[3:0], 4'h5);
      chk("glitch_err", last_err, 0);
    end
    // exact timeout onset, measured from the publish that followed the last accept
    target = fv_cyc + TMO - 2;
    while (cyc < target) @(negedge clk);
    chk("lost_before_timeout", display_lost, 0);
    @(negedge clk);
    chk("lost_at_timeout", display_lost, 1);
    m_seen = 6'd0;
    slot(6'd1, {1'b0, 7'h7D});
    chk("lost_drops_on_accept", display_lost, 0);
    scan(tbl[0].segs, tbl[0].dp, 1, 2);
    for (int i = 0; i < 400 && !display_lost; i++) @(negedge clk);
    chk("lost_after_partial", display_lost, 1);
    m_seen = 6'd0;
    f0 = frames;
    scan(tbl[0].segs, tbl[0].dp, 3, 5);
    chk("timeout_cleared_seen", frames, f0);
    scan(tbl[0].segs, tbl[0].dp, 0, 2);
    wait_frame(f0);
    chk("after_timeout_publish", frames, f0 + 1);
    chk("after_timeout_data", last_d, 24'h123456);
    // reset mid-frame discards partial progress
    scan(tbl[4].segs, tbl[4].dp, 0, 2);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_data", data, 0);
    chk("midrst_digit_en", digit_enable, 0);
    chk("midrst_dp", decimal_point_enable, 0);
    chk("midrst_frame_valid", frame_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    f0 = frames;
    scan(tbl[4].segs, tbl[4].dp, 3, 5);
    chk("midrst_no_publish", frames, f0);
    scan(tbl[4].segs, tbl[4].dp, 0, 5);
    wait_frame(f0);
    chk("midrst_full_scan", frames, f0 + 1);
    chk("midrst_data_after", last_d, 24'hFEDC87);
    // randomized slots against the frame model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        e = 6'd0;
        while ($countones(e) < 2) e = 6'($urandom_range(3, 63));
      end else e = 6'(1 << $urandom_range(0, 5));
      case ($urandom_range(0, 9))
        7: s[6:0] = 7'd0;
        8, 9: s[6:0] = 7'($urandom);
        default: s[6:0] = hex_tab[$urandom_range(0, 15)];
      endcase
      s[7] = 1'($urandom);
      slot(e, s);
    end
    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
